// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path:
// opcodes, ALU and bus select codes, CCR bit positions, sequencer states.
package cpu_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_AND_AB  = 8'h44;
    localparam logic [7:0] OP_OR_AB   = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_DECA    = 8'h47;
    localparam logic [7:0] OP_INCB    = 8'h48;
    localparam logic [7:0] OP_DECB    = 8'h49;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BEQ     = 8'h22;
    localparam logic [7:0] OP_BNE     = 8'h23;
    localparam logic [7:0] OP_BVS     = 8'h24;
    localparam logic [7:0] OP_BCS     = 8'h25;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_INCA = 3'b100;
    localparam logic [2:0] ALU_DECA = 3'b101;
    localparam logic [2:0] ALU_INCB = 3'b110;
    localparam logic [2:0] ALU_DECB = 3'b111;

    localparam logic [1:0] FROM_ALU    = 2'b00;
    localparam logic [1:0] FROM_TO_BUS = 2'b01;
    localparam logic [1:0] FROM_MEM    = 2'b10;

    localparam logic [1:0] TO_PC = 2'b00;
    localparam logic [1:0] TO_A  = 2'b01;
    localparam logic [1:0] TO_B  = 2'b10;

    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

    typedef enum logic [4:0] {
        S_FETCH_0 = 5'd0,
        S_FETCH_1 = 5'd1,
        S_FETCH_2 = 5'd2,
        S_DECODE  = 5'd3,
        S_LI0     = 5'd4,
        S_LI1     = 5'd5,
        S_LI2     = 5'd6,
        S_LD0     = 5'd7,
        S_LD1     = 5'd8,
        S_LD2     = 5'd9,
        S_LD3     = 5'd10,
        S_ST0     = 5'd11,
        S_ST1     = 5'd12,
        S_ST2     = 5'd13,
        S_ST3     = 5'd14,
        S_AL0     = 5'd15,
        S_BR0     = 5'd16,
        S_BR1     = 5'd17,
        S_BSKIP   = 5'd18,
        S_HALT    = 5'd19
    } state_t;

    // ALU opcodes 0x42..0x49 map onto ALU_SEL 0..7 in order.
    function automatic logic [2:0] alu_code(input logic [7:0] op);
        return op[2:0] - 3'd2;
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluation: decides from opcode and NZVC flags
// whether a conditional branch is taken.
module branch_eval
    import cpu_pkg::*;
(
    input  logic [7:0] IR,
    input  logic [3:0] CCR,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (IR)
            OP_BRA:  taken = 1'b1;
            OP_BMI:  taken = CCR[CCR_N];
            OP_BEQ:  taken = CCR[CCR_Z];
            OP_BNE:  taken = ~CCR[CCR_Z];
            OP_BVS:  taken = CCR[CCR_V];
            OP_BCS:  taken = CCR[CCR_C];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Moore control sequencer for the 8-bit CPU: fetch, decode and
// per-state control strobes for the data path and memory.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH_0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR,
    output logic       IR_LOAD,
    output logic       MAR_LOAD,
    output logic       PC_LOAD,
    output logic       PC_INC,
    output logic       A_LOAD,
    output logic       B_LOAD,
    output logic [2:0] ALU_SEL,
    output logic       CCR_LOAD,
    output logic [1:0] FROM_MEMORY_BUS_SEL,
    output logic [1:0] TO_MEMORY_BUS_SEL,
    output logic       mem_write,
    output logic       halted
);

    state_t state;
    state_t state_nxt;
    logic   br_taken;
    logic   sel_b;

    branch_eval u_branch_eval (
        .IR    (IR),
        .CCR   (CCR),
        .taken (br_taken)
    );

    // Instructions whose destination or source register is B.
    assign sel_b = (IR == OP_LDB_IMM) || (IR == OP_LDB_DIR) ||
                   (IR == OP_STB_DIR) || (IR == OP_INCB) ||
                   (IR == OP_DECB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = RESET_STATE;
        case (state)
            S_FETCH_0: state_nxt = S_FETCH_1;
            S_FETCH_1: state_nxt = S_FETCH_2;
            S_FETCH_2: state_nxt = S_DECODE;
            S_DECODE: begin
                unique case (IR)
                    OP_LDA_IMM, OP_LDB_IMM:
                        state_nxt = S_LI0;
                    OP_LDA_DIR, OP_LDB_DIR:
                        state_nxt = S_LD0;
                    OP_STA_DIR, OP_STB_DIR:
                        state_nxt = S_ST0;
                    OP_ADD_AB, OP_SUB_AB, OP_AND_AB, OP_OR_AB,
                    OP_INCA, OP_DECA, OP_INCB, OP_DECB:
                        state_nxt = S_AL0;
                    OP_BRA, OP_BMI, OP_BEQ, OP_BNE, OP_BVS, OP_BCS:
                        state_nxt = br_taken ? S_BR0 : S_BSKIP;
                    OP_HALT:
                        state_nxt = S_HALT;
                    default:
                        state_nxt = S_FETCH_0;
                endcase
            end
            S_LI0:   state_nxt = S_LI1;
            S_LI1:   state_nxt = S_LI2;
            S_LI2:   state_nxt = S_FETCH_0;
            S_LD0:   state_nxt = S_LD1;
            S_LD1:   state_nxt = S_LD2;
            S_LD2:   state_nxt = S_LD3;
            S_LD3:   state_nxt = S_FETCH_0;
            S_ST0:   state_nxt = S_ST1;
            S_ST1:   state_nxt = S_ST2;
            S_ST2:   state_nxt = S_ST3;
            S_ST3:   state_nxt = S_FETCH_0;
            S_AL0:   state_nxt = S_FETCH_0;
            S_BR0:   state_nxt = S_BR1;
            S_BR1:   state_nxt = S_FETCH_0;
            S_BSKIP: state_nxt = S_FETCH_0;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH_0;
        endcase
    end

    always_comb begin
        IR_LOAD             = 1'b0;
        MAR_LOAD            = 1'b0;
        PC_LOAD             = 1'b0;
        PC_INC              = 1'b0;
        A_LOAD              = 1'b0;
        B_LOAD              = 1'b0;
        ALU_SEL             = ALU_ADD;
        CCR_LOAD            = 1'b0;
        FROM_MEMORY_BUS_SEL = FROM_ALU;
        TO_MEMORY_BUS_SEL   = TO_PC;
        mem_write           = 1'b0;
        halted              = 1'b0;
        case (state)
            S_FETCH_0, S_LI0, S_LD0, S_ST0, S_BR0: begin
                FROM_MEMORY_BUS_SEL = FROM_TO_BUS;
                MAR_LOAD            = 1'b1;
            end
            S_FETCH_1, S_LI1, S_LD1, S_ST1, S_BSKIP: begin
                PC_INC = 1'b1;
            end
            S_FETCH_2: begin
                FROM_MEMORY_BUS_SEL = FROM_MEM;
                IR_LOAD             = 1'b1;
            end
            S_LI2, S_LD3: begin
                FROM_MEMORY_BUS_SEL = FROM_MEM;
                A_LOAD              = ~sel_b;
                B_LOAD              = sel_b;
            end
            // Operand byte is the direct address: chase it into MAR.
            S_LD2, S_ST2: begin
                FROM_MEMORY_BUS_SEL = FROM_MEM;
                MAR_LOAD            = 1'b1;
            end
            S_ST3: begin
                TO_MEMORY_BUS_SEL = sel_b ? TO_B : TO_A;
                mem_write         = 1'b1;
            end
            S_AL0: begin
                ALU_SEL  = alu_code(IR);
                CCR_LOAD = 1'b1;
                A_LOAD   = ~sel_b;
                B_LOAD   = sel_b;
            end
            S_BR1: begin
                FROM_MEMORY_BUS_SEL = FROM_MEM;
                PC_LOAD             = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a tiny data path and memory around the DUT,
// with per-cycle strobe traces and ISA-level results checked against a model.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] IR;
    logic [3:0] CCR;
    logic       IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD;
    logic [2:0] ALU_SEL;
    logic       CCR_LOAD, mem_write, halted;
    logic [1:0] FROM_MEMORY_BUS_SEL, TO_MEMORY_BUS_SEL;

    instr_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .IR                  (IR),
        .CCR                 (CCR),
        .IR_LOAD             (IR_LOAD),
        .MAR_LOAD            (MAR_LOAD),
        .PC_LOAD             (PC_LOAD),
        .PC_INC              (PC_INC),
        .A_LOAD              (A_LOAD),
        .B_LOAD              (B_LOAD),
        .ALU_SEL             (ALU_SEL),
        .CCR_LOAD            (CCR_LOAD),
        .FROM_MEMORY_BUS_SEL (FROM_MEMORY_BUS_SEL),
        .TO_MEMORY_BUS_SEL   (TO_MEMORY_BUS_SEL),
        .mem_write           (mem_write),
        .halted              (halted)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] V_IRL = 16'h0001;
    localparam logic [15:0] V_MAR = 16'h0002;
    localparam logic [15:0] V_PCL = 16'h0004;
    localparam logic [15:0] V_PCI = 16'h0008;
    localparam logic [15:0] V_AL  = 16'h0010;
    localparam logic [15:0] V_BL  = 16'h0020;
    localparam logic [15:0] V_CCL = 16'h0200;
    localparam logic [15:0] V_FTO = 16'h0400;
    localparam logic [15:0] V_FME = 16'h0800;
    localparam logic [15:0] V_TOA = 16'h1000;
    localparam logic [15:0] V_TOB = 16'h2000;
    localparam logic [15:0] V_MW  = 16'h4000;
    localparam logic [15:0] V_HLT = 16'h8000;
    localparam logic [15:0] V_F0  = V_MAR | V_FTO;

    logic [15:0] obs;
    assign obs = {halted, mem_write, TO_MEMORY_BUS_SEL, FROM_MEMORY_BUS_SEL,
                  CCR_LOAD, ALU_SEL, B_LOAD, A_LOAD, PC_INC, PC_LOAD,
                  MAR_LOAD, IR_LOAD};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ALU: sel order ADD SUB AND OR INCA DECA INCB DECB; returns {NZVC, result}.
    function automatic logic [11:0] alu(input logic [2:0] sel,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
        logic [8:0] r;
        logic       v;
        v = 1'b0;
        case (sel)
            3'd0: begin
                r = {1'b0, a} + {1'b0, b};
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd1: begin
                r = {1'b0, a} - {1'b0, b};
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd2: r = {1'b0, a & b};
            3'd3: r = {1'b0, a | b};
            3'd4: begin r = {1'b0, a} + 9'd1; v = (a == 8'h7F); end
            3'd5: begin r = {1'b0, a} - 9'd1; v = (a == 8'h80); end
            3'd6: begin r = {1'b0, b} + 9'd1; v = (b == 8'h7F); end
            default: begin r = {1'b0, b} - 9'd1; v = (b == 8'h80); end
        endcase
        return {r[7], r[7:0] == 8'h00, v, r[8], r[7:0]};
    endfunction

    // Small data path driven by the sequencer strobes.
    logic [7:0]  mem [256];
    logic [7:0]  dp_ir = 8'h00, dp_mar = 8'h00, dp_pc = 8'h00;
    logic [7:0]  dp_a = 8'h00, dp_b = 8'h00;
    logic [3:0]  dp_ccr = 4'h0;
    logic [7:0]  to_bus, from_bus;
    logic [11:0] alu_out;
    int          a_loads = 0;

    assign IR      = dp_ir;
    assign CCR     = dp_ccr;
    assign alu_out = alu(ALU_SEL, dp_a, dp_b);
    assign to_bus  = (TO_MEMORY_BUS_SEL == 2'b01) ? dp_a :
                     (TO_MEMORY_BUS_SEL == 2'b10) ? dp_b : dp_pc;
    assign from_bus = (FROM_MEMORY_BUS_SEL == 2'b00) ? alu_out[7:0] :
                      (FROM_MEMORY_BUS_SEL == 2'b01) ? to_bus : mem[dp_mar];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_pc <= 8'h00;
        end else begin
            if (IR_LOAD) dp_ir <= from_bus;
            if (MAR_LOAD) dp_mar <= from_bus;
            if (PC_LOAD) dp_pc <= from_bus;
            else if (PC_INC) dp_pc <= dp_pc + 8'd1;
            if (A_LOAD) begin
                dp_a <= from_bus;
                a_loads <= a_loads + 1;
            end
            if (B_LOAD) dp_b <= from_bus;
            if (CCR_LOAD) dp_ccr <= alu_out[11:8];
            if (mem_write) mem[dp_mar] = to_bus;
        end
    end

    // ISA-level reference state.
    logic [7:0]  ref_pc = 8'h00, ref_a = 8'h00, ref_b = 8'h00;
    logic [3:0]  ref_ccr = 4'h0;
    logic [15:0] exp_q[$];

    function automatic bit is_alu(input logic [7:0] op);
        return op >= 8'h42 && op <= 8'h49;
    endfunction

    function automatic bit is_br(input logic [7:0] op);
        return op >= 8'h20 && op <= 8'h25;
    endfunction

    function automatic bit known(input logic [7:0] op);
        return (op inside {8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'hFF})
               || is_alu(op) || is_br(op);
    endfunction

    function automatic bit br_cond(input logic [7:0] op, input logic [3:0] f);
        case (op)
            8'h20:   return 1'b1;
            8'h21:   return f[3];
            8'h22:   return f[2];
            8'h23:   return ~f[2];
            8'h24:   return f[1];
            default: return f[0];
        endcase
    endfunction

    // Expected output vector for every cycle from FETCH_0 to the next FETCH_0.
    task automatic expect_trace(input logic [7:0] op, input logic [3:0] f);
        int idx;
        exp_q = {V_F0, V_PCI, V_FME | V_IRL, 16'h0000};
        if (op == 8'h86 || op == 8'h88) begin
            exp_q.push_back(V_F0);
            exp_q.push_back(V_PCI);
            exp_q.push_back(V_FME | (op == 8'h86 ? V_AL : V_BL));
        end else if (op == 8'h87 || op == 8'h89) begin
            exp_q.push_back(V_F0);
            exp_q.push_back(V_PCI);
            exp_q.push_back(V_FME | V_MAR);
            exp_q.push_back(V_FME | (op == 8'h87 ? V_AL : V_BL));
        end else if (op == 8'h96 || op == 8'h97) begin
            exp_q.push_back(V_F0);
            exp_q.push_back(V_PCI);
            exp_q.push_back(V_FME | V_MAR);
            exp_q.push_back(V_MW | (op == 8'h96 ? V_TOA : V_TOB));
        end else if (is_alu(op)) begin
            idx = int'(op) - 'h42;
            exp_q.push_back(V_CCL | (16'(idx) << 6) | (idx >= 6 ? V_BL : V_AL));
        end else if (is_br(op)) begin
            if (br_cond(op, f)) begin
                exp_q.push_back(V_F0);
                exp_q.push_back(V_FME | V_PCL);
            end else begin
                exp_q.push_back(V_PCI);
            end
        end else if (op == 8'hFF) begin
            for (int i = 0; i < 20; i++) exp_q.push_back(V_HLT);
        end
    endtask

    task automatic run_instr(input logic [7:0] op, input logic [7:0] opnd);
        logic [7:0]  nxt_pc, st_val;
        logic [11:0] r;
        bit          do_st;
        int          idx;
        mem[ref_pc] = op;
        mem[ref_pc + 8'd1] = opnd;
        expect_trace(op, ref_ccr);
        do_st  = 1'b0;
        st_val = 8'h00;
        nxt_pc = ref_pc + 8'd2;
        if (op == 8'h86) ref_a = opnd;
        else if (op == 8'h88) ref_b = opnd;
        else if (op == 8'h87) ref_a = mem[opnd];
        else if (op == 8'h89) ref_b = mem[opnd];
        else if (op == 8'h96 || op == 8'h97) begin
            do_st  = 1'b1;
            st_val = (op == 8'h96) ? ref_a : ref_b;
        end else if (is_alu(op)) begin
            idx = int'(op) - 'h42;
            r = alu(3'(idx), ref_a, ref_b);
            if (idx >= 6) ref_b = r[7:0];
            else ref_a = r[7:0];
            ref_ccr = r[11:8];
            nxt_pc = ref_pc + 8'd1;
        end else if (is_br(op)) begin
            if (br_cond(op, ref_ccr)) nxt_pc = opnd;
        end else begin
            nxt_pc = ref_pc + 8'd1;
        end
        ref_pc = nxt_pc;
        foreach (exp_q[i]) begin
            #1;
            check($sformatf("op%02h_cyc%0d", op, i), 32'(obs), 32'(exp_q[i]));
            @(negedge clk);
        end
        check($sformatf("arch_op%02h", op),
              {4'h0, dp_ccr, dp_pc, dp_b, dp_a},
              {4'h0, ref_ccr, ref_pc, ref_b, ref_a});
        if (do_st) check($sformatf("store_%02h", opnd), 32'(mem[opnd]), 32'(st_val));
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1 check("rst_async", 32'(obs), 32'(V_F0));
        repeat (2) @(negedge clk);
        check("rst_hold", 32'(obs), 32'(V_F0));
        reset = 1'b1;
        ref_pc = 8'h00;
    endtask

    task automatic run_random(input int n);
        logic [7:0] op;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 6))
                0: op = $urandom_range(0, 1) ? 8'h86 : 8'h88;
                1: op = $urandom_range(0, 1) ? 8'h87 : 8'h89;
                2: op = $urandom_range(0, 1) ? 8'h96 : 8'h97;
                3, 6: op = 8'h42 + 8'($urandom_range(0, 7));
                4: op = 8'h20 + 8'($urandom_range(0, 5));
                default: begin
                    op = 8'($urandom);
                    while (known(op)) op = 8'($urandom);
                end
            endcase
            run_instr(op, 8'($urandom));
        end
    endtask

    initial begin
        int snap;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out", 32'(obs), 32'(V_F0));
        reset = 1'b1;

        run_instr(8'h86, 8'h5A);
        run_instr(8'h86, 8'h33);
        run_instr(8'h96, 8'h80);
        run_instr(8'h86, 8'h7F);
        run_instr(8'h88, 8'h01);
        run_instr(8'h42, 8'h00);
        check("add_ccr", 32'(dp_ccr), 32'h0000_000A);
        run_instr(8'h88, 8'h80);
        run_instr(8'h43, 8'h00);
        run_instr(8'h22, 8'h10);
        check("beq_taken_pc", 32'(dp_pc), 32'h0000_0010);
        run_instr(8'h86, 8'h01);
        run_instr(8'h88, 8'h01);
        run_instr(8'h44, 8'h00);
        run_instr(8'h22, 8'h10);
        run_instr(8'h00, 8'h00);

        run_random(300);

        run_instr(8'hFF, 8'h00);
        pulse_reset();
        run_random(10);

        // Abort a direct load in LD2: A must never be written.
        mem[ref_pc] = 8'h87;
        mem[ref_pc + 8'd1] = 8'h40;
        expect_trace(8'h87, ref_ccr);
        snap = a_loads;
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("abort_cyc%0d", i), 32'(obs), 32'(exp_q[i]));
            if (i < 6) @(negedge clk);
        end
        pulse_reset();
        check("abort_no_aload", 32'(a_loads), 32'(snap));
        check("abort_a", 32'(dp_a), 32'(ref_a));

        run_random(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Moore-FSM control sequencer for the 8-bit CPU data path. It fetches and decodes the opcode in IR, then drives the register load strobes, ALU operation select, bus mux selects and memory write strobe cycle by cycle. It reads CCR (NZVC) to resolve conditional branches. It connects directly to the data path control inputs, and its memory write strobe goes to the memory block.

Parameters:
RESET_STATE, S_FETCH_0, state entered on reset and after every instruction.

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  asynchronous active-low reset
IR  in  8  current opcode from data path
CCR  in  4  flags {N,Z,V,C}, N = bit 3
IR_LOAD  out  1  load IR from FROM_MEMORY_BUS
MAR_LOAD  out  1  load MAR from FROM_MEMORY_BUS
PC_LOAD  out  1  load PC from FROM_MEMORY_BUS
PC_INC  out  1  increment PC
A_LOAD  out  1  load A from FROM_MEMORY_BUS
B_LOAD  out  1  load B from FROM_MEMORY_BUS
ALU_SEL  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 INCA, 101 DECA, 110 INCB, 111 DECB
CCR_LOAD  out  1  latch ALU NZVC into CCR
FROM_MEMORY_BUS_SEL  out  2  00 ALU result, 01 TO_MEMORY_BUS, 10 memory data
TO_MEMORY_BUS_SEL  out  2  00 PC, 01 A, 10 B
mem_write  out  1  write TO_MEMORY_BUS to memory at MAR this cycle
halted  out  1  high while in S_HALT

Behaviour:
- Reset and clock: reset is asynchronous and active-low. While reset=0, state = S_FETCH_0. All outputs are a pure function of state (Moore).
- Default outputs: every strobe 0, ALU_SEL=000, both sel=00, unless listed for a state.
- S_FETCH_0: TO_SEL=00, FROM_SEL=01, MAR_LOAD=1 (MAR<=PC). These are also the outputs held during reset.
- S_FETCH_1: PC_INC=1.
- S_FETCH_2: FROM_SEL=10, IR_LOAD=1.
- S_DECODE: no strobes. Next state chosen from IR.
- Opcodes:
  - LDA_IMM 0x86, LDB_IMM 0x88
  - LDA_DIR 0x87, LDB_DIR 0x89
  - STA_DIR 0x96, STB_DIR 0x97
  - ADD_AB 0x42, SUB_AB 0x43, AND_AB 0x44, OR_AB 0x45, INCA 0x46, DECA 0x47, INCB 0x48, DECB 0x49
  - BRA 0x20, BMI 0x21, BEQ 0x22, BNE 0x23, BVS 0x24, BCS 0x25
  - HALT 0xFF
- Immediate load, states LI0..LI2:
  - LI0: MAR<=PC (as FETCH_0).
  - LI1: PC_INC.
  - LI2: FROM_SEL=10, A_LOAD or B_LOAD per IR.
- Direct load, states LD0..LD3:
  - LD0, LD1: as LI0, LI1.
  - LD2: FROM_SEL=10, MAR_LOAD.
  - LD3: FROM_SEL=10, A_LOAD or B_LOAD.
- Direct store, states ST0..ST3:
  - ST0..ST2: as LD0..LD2.
  - ST3: TO_SEL=01 (A) or 10 (B), mem_write=1.
- ALU ops, state AL0: FROM_SEL=00, CCR_LOAD=1, ALU_SEL per opcode order above.
  - A_LOAD for ADD/SUB/AND/OR/INCA/DECA.
  - B_LOAD for INCB/DECB.
- Branches:
  - Condition: BRA always taken; BMI N=1; BEQ Z=1; BNE Z=0; BVS V=1; BCS C=1.
  - CCR is sampled in S_DECODE.
  - Taken: BR0 MAR<=PC, then BR1 FROM_SEL=10, PC_LOAD.
  - Not taken: BSKIP PC_INC (skips the operand byte).
- HALT: S_HALT, halted=1, all strobes 0. Stays there until reset.
- Unknown opcode: acts as NOP, S_DECODE goes to S_FETCH_0.
- Cycle counts, from entering S_FETCH_0 back to S_FETCH_0: NOP 4, ALU 5, LD_IMM 7, LD_DIR 8, ST_DIR 8, branch taken 6, branch not taken 5.
- Mutual exclusion: at most one of PC_LOAD/PC_INC asserted per cycle, and mem_write is never asserted together with any *_LOAD.
- Reset mid-instruction: reset takes effect immediately in any state; no partial store completes after reset asserts.
- Encoding: state register is 5 bits binary. Any illegal state encoding goes to S_FETCH_0 next cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams
  - ALU_SEL codes
  - FROM/TO bus select codes
  - the state enumeration
  - CCR bit indices
- Sub-module branch_eval: combinational (IR, CCR) -> taken. It is unit-testable on its own.

Test Plan:
- Release reset with memory [0]=0x86, [1]=0x5A: IR_LOAD in cycle 2, A_LOAD with FROM_SEL=10 in cycle 6, S_FETCH_0 in cycle 7; A=0x5A.
- STA_DIR 0x96, 0x80, with A=0x33: MAR_LOAD with FROM_SEL=10 in cycle 6; mem_write=1 with TO_SEL=01 in cycle 7; mem[0x80]=0x33; no load strobes in cycle 7.
- ADD_AB 0x42, with A=0x7F, B=0x01: ALU_SEL=000, FROM_SEL=00, A_LOAD and CCR_LOAD in cycle 4; A=0x80, CCR=1010.
- BEQ 0x22 operand 0x10: with CCR=0100, PC_LOAD in cycle 5 and PC=0x10. With CCR=0000, PC_INC only in cycle 4 and PC=operand address+1.
- Opcode 0x00 -> 4-cycle NOP. Opcode 0xFF -> halted=1 and no strobes for 20 cycles; reset low then high returns to S_FETCH_0 with halted=0.
- Assert reset during LD2 of LDA_DIR: state = S_FETCH_0 asynchronously; A_LOAD never pulses; the sequence restarts correctly after release.
